// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding for the pipelined RV32I core.
// Holds the decoded instruction for one cycle and feeds forwarded operands straight into the ALU.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  StallE,
  input  logic                  FlushE,
  input  logic                  ValidD,
  input  logic [XLEN-1:0]       RD1D,
  input  logic [XLEN-1:0]       RD2D,
  input  logic [XLEN-1:0]       ImmExtD,
  input  logic [XLEN-1:0]       PCD,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic [3:0]            ALUControlD,
  input  logic                  ALUSrcD,
  input  logic                  SrcASelD,
  input  logic                  RegWriteD,
  input  logic                  MemWriteD,
  input  logic                  BranchD,
  input  logic                  JumpD,
  input  logic [1:0]            ResultSrcD,
  input  logic [XLEN-1:0]       ALUResultM,
  input  logic [XLEN-1:0]       ResultW,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  output logic [XLEN-1:0]       SrcAE,
  output logic [XLEN-1:0]       SrcBE,
  output logic [3:0]            ALUControlE,
  output logic [XLEN-1:0]       WriteDataE,
  output logic [XLEN-1:0]       ImmExtE,
  output logic [XLEN-1:0]       PCE,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic [REG_ADDR_W-1:0] Rs1E,
  output logic [REG_ADDR_W-1:0] Rs2E,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  BranchE,
  output logic                  JumpE,
  output logic [1:0]            ResultSrcE,
  output logic                  ValidE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE
);

  logic [XLEN-1:0] rd1_e;
  logic [XLEN-1:0] rd2_e;
  logic            alu_src_e;
  logic            srca_sel_e;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  // A flush inserts the same all-zero bubble as reset; a bubble decodes as an invalid ADD.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      ValidE      <= 1'b0;
      rd1_e       <= '0;
      rd2_e       <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      ALUControlE <= '0;
      alu_src_e   <= 1'b0;
      srca_sel_e  <= 1'b0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      JumpE       <= 1'b0;
      ResultSrcE  <= '0;
    end else if (!StallE) begin
      ValidE      <= ValidD;
      rd1_e       <= RD1D;
      rd2_e       <= RD2D;
      ImmExtE     <= ImmExtD;
      PCE         <= PCD;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= RdD;
      ALUControlE <= ALUControlD;
      alu_src_e   <= ALUSrcD;
      srca_sel_e  <= SrcASelD;
      RegWriteE   <= RegWriteD & ValidD;
      MemWriteE   <= MemWriteD & ValidD;
      BranchE     <= BranchD & ValidD;
      JumpE       <= JumpD & ValidD;
      ResultSrcE  <= ResultSrcD;
    end
  end

  // MEM is younger than WB, so its result wins; x0 is hardwired and never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E)) begin
      ForwardAE = 2'b10;
    end else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) begin
      ForwardAE = 2'b01;
    end
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E)) begin
      ForwardBE = 2'b10;
    end else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) begin
      ForwardBE = 2'b01;
    end
  end

  always_comb begin
    fwd_a = rd1_e;
    fwd_b = rd2_e;
    case (ForwardAE)
      2'b10:   fwd_a = ALUResultM;
      2'b01:   fwd_a = ResultW;
      default: fwd_a = rd1_e;
    endcase
    case (ForwardBE)
      2'b10:   fwd_b = ALUResultM;
      2'b01:   fwd_b = ResultW;
      default: fwd_b = rd2_e;
    endcase
  end

  // Stores always need the real rs2 value, even when the ALU takes the immediate.
  assign WriteDataE = fwd_b;
  assign SrcAE      = srca_sel_e ? PCE : fwd_a;
  assign SrcBE      = alu_src_e ? ImmExtE : fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts EX outputs from the
// instruction last accepted into the stage and the current MEM/WB forwarding sources.
module tb_id_ex_stage;

  typedef struct packed {
    logic        reset;
    logic        StallE;
    logic        FlushE;
    logic        ValidD;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] ImmExtD;
    logic [31:0] PCD;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [4:0]  RdD;
    logic [3:0]  ALUControlD;
    logic        ALUSrcD;
    logic        SrcASelD;
    logic        RegWriteD;
    logic        MemWriteD;
    logic        BranchD;
    logic        JumpD;
    logic [1:0]  ResultSrcD;
    logic [31:0] ALUResultM;
    logic [31:0] ResultW;
    logic [4:0]  RdM;
    logic [4:0]  RdW;
    logic        RegWriteM;
    logic        RegWriteW;
  } stim_t;

  // The instruction the model believes occupies the EX slot.
  typedef struct packed {
    logic        valid;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic        srca_sel;
    logic        reg_write;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic [1:0]  result_src;
  } instr_t;

  typedef struct packed {
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] write_data;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  alu_ctrl;
    logic        reg_write;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic [1:0]  result_src;
    logic        valid;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        StallE, FlushE, ValidD;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [3:0]  ALUControlD;
  logic        ALUSrcD, SrcASelD, RegWriteD, MemWriteD, BranchD, JumpD;
  logic [1:0]  ResultSrcD;
  logic [31:0] ALUResultM, ResultW;
  logic [4:0]  RdM, RdW;
  logic        RegWriteM, RegWriteW;
  logic [31:0] SrcAE, SrcBE, WriteDataE, ImmExtE, PCE;
  logic [3:0]  ALUControlE;
  logic [4:0]  RdE, Rs1E, Rs2E;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, ValidE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;

  int     checks;
  int     failures;
  exp_t   sb_q[$];
  stim_t  cur;
  instr_t model;

  id_ex_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUControlD(ALUControlD),
    .ALUSrcD(ALUSrcD), .SrcASelD(SrcASelD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .BranchD(BranchD), .JumpD(JumpD), .ResultSrcD(ResultSrcD),
    .ALUResultM(ALUResultM), .ResultW(ResultW), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE), .WriteDataE(WriteDataE),
    .ImmExtE(ImmExtE), .PCE(PCE), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
    .ResultSrcE(ResultSrcE), .ValidE(ValidE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t randStim();
    stim_t s;
    s.reset       = 1'b0;
    s.StallE      = 1'b0;
    s.FlushE      = 1'b0;
    s.ValidD      = ($urandom_range(0, 3) != 0);
    s.RD1D        = $urandom;
    s.RD2D        = $urandom;
    s.ImmExtD     = $urandom;
    s.PCD         = $urandom;
    s.Rs1D        = 5'($urandom_range(0, 7));
    s.Rs2D        = 5'($urandom_range(0, 7));
    s.RdD         = 5'($urandom_range(0, 31));
    s.ALUControlD = 4'($urandom);
    s.ALUSrcD     = 1'($urandom);
    s.SrcASelD    = 1'($urandom);
    s.RegWriteD   = 1'($urandom);
    s.MemWriteD   = 1'($urandom);
    s.BranchD     = 1'($urandom);
    s.JumpD       = 1'($urandom);
    s.ResultSrcD  = 2'($urandom);
    s.ALUResultM  = $urandom;
    s.ResultW     = $urandom;
    s.RdM         = 5'($urandom_range(0, 7));
    s.RdW         = 5'($urandom_range(0, 7));
    s.RegWriteM   = 1'($urandom);
    s.RegWriteW   = 1'($urandom);
    return s;
  endfunction

  // Younger MEM producer beats WB; a write to x0 never counts as a producer.
  function automatic void resolve(input logic [4:0] rs, input logic [31:0] rf, input stim_t s,
                                  output logic [1:0] sel, output logic [31:0] val);
    if (s.RegWriteM && s.RdM != 5'd0 && s.RdM == rs) begin
      sel = 2'b10;
      val = s.ALUResultM;
    end else if (s.RegWriteW && s.RdW != 5'd0 && s.RdW == rs) begin
      sel = 2'b01;
      val = s.ResultW;
    end else begin
      sel = 2'b00;
      val = rf;
    end
  endfunction

  function automatic exp_t predict(input instr_t m, input stim_t s);
    exp_t        e;
    logic [31:0] a_val, b_val;
    logic [1:0]  a_sel, b_sel;
    resolve(m.rs1, m.rd1, s, a_sel, a_val);
    resolve(m.rs2, m.rd2, s, b_sel, b_val);
    e.src_a      = m.srca_sel ? m.pc : a_val;
    e.src_b      = m.alu_src ? m.imm : b_val;
    e.write_data = b_val;
    e.imm        = m.imm;
    e.pc         = m.pc;
    e.rd         = m.rd;
    e.rs1        = m.rs1;
    e.rs2        = m.rs2;
    e.alu_ctrl   = m.alu_ctrl;
    e.reg_write  = m.reg_write;
    e.mem_write  = m.mem_write;
    e.branch     = m.branch;
    e.jump       = m.jump;
    e.result_src = m.result_src;
    e.valid      = m.valid;
    e.fwd_a      = a_sel;
    e.fwd_b      = b_sel;
    return e;
  endfunction

  function automatic instr_t nextSlot(input instr_t m, input stim_t s);
    instr_t n;
    if (s.reset || s.FlushE) begin
      n = '0;
    end else if (s.StallE) begin
      n = m;
    end else begin
      n.valid      = s.ValidD;
      n.rd1        = s.RD1D;
      n.rd2        = s.RD2D;
      n.imm        = s.ImmExtD;
      n.pc         = s.PCD;
      n.rs1        = s.Rs1D;
      n.rs2        = s.Rs2D;
      n.rd         = s.RdD;
      n.alu_ctrl   = s.ALUControlD;
      n.alu_src    = s.ALUSrcD;
      n.srca_sel   = s.SrcASelD;
      n.reg_write  = s.ValidD ? s.RegWriteD : 1'b0;
      n.mem_write  = s.ValidD ? s.MemWriteD : 1'b0;
      n.branch     = s.ValidD ? s.BranchD : 1'b0;
      n.jump       = s.ValidD ? s.JumpD : 1'b0;
      n.result_src = s.ResultSrcD;
    end
    return n;
  endfunction

  task automatic driveInputs(input stim_t s);
    reset = s.reset; StallE = s.StallE; FlushE = s.FlushE; ValidD = s.ValidD;
    RD1D = s.RD1D; RD2D = s.RD2D; ImmExtD = s.ImmExtD; PCD = s.PCD;
    Rs1D = s.Rs1D; Rs2D = s.Rs2D; RdD = s.RdD; ALUControlD = s.ALUControlD;
    ALUSrcD = s.ALUSrcD; SrcASelD = s.SrcASelD; RegWriteD = s.RegWriteD;
    MemWriteD = s.MemWriteD; BranchD = s.BranchD; JumpD = s.JumpD; ResultSrcD = s.ResultSrcD;
    ALUResultM = s.ALUResultM; ResultW = s.ResultW; RdM = s.RdM; RdW = s.RdW;
    RegWriteM = s.RegWriteM; RegWriteW = s.RegWriteW;
  endtask

  // One clock: the slot absorbs what was driven before the edge, then new inputs go out
  // and the response expected for the rest of this cycle is queued.
  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    model = nextSlot(model, cur);
    #1;
    cur = s;
    driveInputs(cur);
    sb_q.push_back(predict(model, cur));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    check("SrcAE", SrcAE, e.src_a);
    check("SrcBE", SrcBE, e.src_b);
    check("WriteDataE", WriteDataE, e.write_data);
    check("ImmExtE", ImmExtE, e.imm);
    check("PCE", PCE, e.pc);
    check("RdE", 32'(RdE), 32'(e.rd));
    check("Rs1E", 32'(Rs1E), 32'(e.rs1));
    check("Rs2E", 32'(Rs2E), 32'(e.rs2));
    check("ALUControlE", 32'(ALUControlE), 32'(e.alu_ctrl));
    check("RegWriteE", 32'(RegWriteE), 32'(e.reg_write));
    check("MemWriteE", 32'(MemWriteE), 32'(e.mem_write));
    check("BranchE", 32'(BranchE), 32'(e.branch));
    check("JumpE", 32'(JumpE), 32'(e.jump));
    check("ResultSrcE", 32'(ResultSrcE), 32'(e.result_src));
    check("ValidE", 32'(ValidE), 32'(e.valid));
    check("ForwardAE", 32'(ForwardAE), 32'(e.fwd_a));
    check("ForwardBE", 32'(ForwardBE), 32'(e.fwd_b));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    stim_t s;
    checks   = 0;
    failures = 0;
    model    = '0;
    cur      = randStim();
    cur.reset = 1'b1;
    driveInputs(cur);

    // Reset with random D inputs, then a plain ADD-style load of 5 and 7.
    s = randStim(); s.ValidD = 1'b1; s.RD1D = 32'd5; s.RD2D = 32'd7; s.Rs1D = 5'd1;
    s.Rs2D = 5'd2; s.ALUSrcD = 1'b0; s.SrcASelD = 1'b0;
    applyStimulus(s);
    s = randStim(); s.StallE = 1'b1; s.RegWriteM = 1'b0; s.RegWriteW = 1'b0;
    applyStimulus(s);

    // Both MEM and WB produce rs1 = x3; MEM must win, then WB once MEM drops out.
    s = randStim(); s.ValidD = 1'b1; s.Rs1D = 5'd3; s.SrcASelD = 1'b0;
    applyStimulus(s);
    s = randStim(); s.StallE = 1'b1; s.RdM = 5'd3; s.RegWriteM = 1'b1; s.ALUResultM = 32'hAA;
    s.RdW = 5'd3; s.RegWriteW = 1'b1; s.ResultW = 32'hBB;
    applyStimulus(s);
    s.RegWriteM = 1'b0;
    applyStimulus(s);

    // A producer writing x0 must not be forwarded.
    s = randStim(); s.ValidD = 1'b1; s.Rs2D = 5'd0; s.RD2D = 32'd0; s.ALUSrcD = 1'b0;
    applyStimulus(s);
    s = randStim(); s.StallE = 1'b1; s.RdM = 5'd0; s.RegWriteM = 1'b1; s.ALUResultM = 32'hFF;
    s.RegWriteW = 1'b0;
    applyStimulus(s);

    // Three stalled cycles with changing D inputs, then flush and stall together.
    s = randStim(); s.ValidD = 1'b1; s.MemWriteD = 1'b1;
    applyStimulus(s);
    for (int i = 0; i < 3; i++) begin
      s = randStim(); s.StallE = 1'b1;
      applyStimulus(s);
    end
    s = randStim(); s.StallE = 1'b1; s.FlushE = 1'b1;
    applyStimulus(s);
    s = randStim();
    applyStimulus(s);

    // Immediate operand while the store data comes forwarded from MEM.
    s = randStim(); s.ValidD = 1'b1; s.ALUSrcD = 1'b1; s.ImmExtD = 32'hFFFF_FFFC; s.Rs2D = 5'd4;
    applyStimulus(s);
    s = randStim(); s.StallE = 1'b1; s.RdM = 5'd4; s.RegWriteM = 1'b1; s.ALUResultM = 32'd9;
    applyStimulus(s);

    for (int i = 0; i < 400; i++) begin
      s = randStim();
      s.reset  = ($urandom_range(0, 49) == 0);
      s.FlushE = ($urandom_range(0, 9) == 0);
      s.StallE = ($urandom_range(0, 4) == 0);
      applyStimulus(s);
    end

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
